// File: rtl/mseq_sample_gen.sv
// 7-bit m-sequence (x^7+x^6+1) sample source: bits packed MSB-first into bytes on a valid/ready port.
// Build option MSEQ_FRAME_MARK_EN raises frame_start with the byte holding step 0 of each 127-bit period.
module mseq_sample_gen #(
  parameter int unsigned DIV  = 4,
  parameter logic [6:0]  SEED = 7'h01
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       enable,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_start
);

  typedef enum logic [1:0] {
    ST_SEED  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_div_cnt;
  logic [6:0]  r_lfsr;
  logic [6:0]  r_shreg;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_data;
  logic [7:0]  r_hold;
  logic        r_data_valid;

  logic       w_lockup;
  logic       w_run;
  logic       w_tick;
  logic       w_fb;
  logic       w_byte_done;
  logic       w_accept;
  logic       w_out_free;
  logic [7:0] w_byte;

  // Handshake: a byte transfers on every edge where data_valid && data_ready; data and
  // data_valid never change while data_valid=1 and data_ready=0.
  assign w_lockup    = (r_state == ST_RUN) && (r_lfsr == 7'd0);
  assign w_run       = (r_state == ST_RUN) && enable && !w_lockup;
  assign w_tick      = w_run && (r_div_cnt == DIV_LAST);
  assign w_fb        = r_lfsr[6] ^ r_lfsr[5];
  assign w_byte      = {r_shreg, w_fb};
  assign w_byte_done = w_tick && (r_bit_cnt == 3'd7);
  assign w_accept    = r_data_valid && data_ready;
  assign w_out_free  = !r_data_valid || data_ready;

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) r_state <= ST_SEED;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SEED:  w_state_nxt = ST_RUN;
      ST_RUN:   if (w_byte_done && !w_out_free) w_state_nxt = ST_STALL;
      ST_STALL: if (data_ready) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_SEED;
    endcase
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_lfsr       <= SEED;
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_data       <= '0;
      r_hold       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      if (w_accept) r_data_valid <= 1'b0;
      case (r_state)
        ST_SEED: begin
          r_lfsr    <= SEED;
          r_div_cnt <= '0;
          r_bit_cnt <= '0;
          r_shreg   <= '0;
        end
        ST_RUN: begin
          // An all-zero LFSR can only come from an upset; reload without stepping.
          if (w_lockup) begin
            r_lfsr <= SEED;
          end else if (w_run) begin
            r_div_cnt <= w_tick ? 16'd0 : r_div_cnt + 16'd1;
            if (w_tick) begin
              r_lfsr    <= {r_lfsr[5:0], w_fb};
              r_shreg   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_byte_done) begin
              if (w_out_free) begin
                r_data       <= w_byte;
                r_data_valid <= 1'b1;
              end else begin
                r_hold <= w_byte;
              end
            end
          end
        end
        ST_STALL: begin
          if (data_ready) begin
            r_data       <= r_hold;
            r_data_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;

`ifdef MSEQ_FRAME_MARK_EN
  logic [6:0] r_step_cnt;
  logic       r_frame_pend;
  logic       r_hold_frame;
  logic       r_frame_start;
  logic       w_step0;
  logic       w_byte_frame;

  // A period boundary may land mid-byte; remember it until that byte completes.
  assign w_step0      = (r_step_cnt == 7'd0);
  assign w_byte_frame = r_frame_pend || w_step0;

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_step_cnt    <= '0;
      r_frame_pend  <= 1'b0;
      r_hold_frame  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_accept) r_frame_start <= 1'b0;
      case (r_state)
        ST_SEED: begin
          r_step_cnt   <= '0;
          r_frame_pend <= 1'b0;
        end
        ST_RUN: begin
          if (w_tick) begin
            r_step_cnt <= (r_step_cnt == 7'd126) ? 7'd0 : r_step_cnt + 7'd1;
            if (w_byte_done) begin
              r_frame_pend <= 1'b0;
              if (w_out_free) r_frame_start <= w_byte_frame;
              else            r_hold_frame  <= w_byte_frame;
            end else if (w_step0) begin
              r_frame_pend <= 1'b1;
            end
          end
        end
        ST_STALL: if (data_ready) r_frame_start <= r_hold_frame;
        default: ;
      endcase
    end
  end

  assign frame_start = r_frame_start;
`else
  assign frame_start = 1'b0;
`endif

endmodule

// File: tb/tb_mseq_sample_gen.sv
// Bench for mseq_sample_gen: a DIV=1 instance for stream, stall, reset and random runs, and a
// DIV=4 instance for latency and enable gating, checked against a recurrence-based bit model.
`timescale 1ns/1ps
module tb_mseq_sample_gen;

  localparam logic [6:0] SEED_V = 7'h01;
  localparam int NBITS  = 4096;
  localparam int NBYTES = NBITS / 8;
`ifdef MSEQ_FRAME_MARK_EN
  localparam bit FRAME_EN = 1'b1;
`else
  localparam bit FRAME_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, en1, rdy1, vld1, fs1;
  logic [7:0] data1;
  logic       rst4, en4, rdy4, vld4, fs4;
  logic [7:0] data4;

  mseq_sample_gen #(.DIV(1), .SEED(SEED_V)) u_dut1 (
    .CLK_50MHZ  (clk),
    .RST        (rst1),
    .enable     (en1),
    .data       (data1),
    .data_valid (vld1),
    .data_ready (rdy1),
    .frame_start(fs1)
  );

  mseq_sample_gen #(.DIV(4), .SEED(SEED_V)) u_dut4 (
    .CLK_50MHZ  (clk),
    .RST        (rst4),
    .enable     (en4),
    .data       (data4),
    .data_valid (vld4),
    .data_ready (rdy4),
    .frame_start(fs4)
  );

  int         n_total = 0;
  int         n_bad   = 0;
  logic       ref_s [NBITS];
  logic [7:0] exp_q [$];
  logic       exp_f_q [$];
  logic       got_bits [$];
  int         cyc1, first_cyc, n_acc, last_acc;
  bit         first_seen, prev_hold, chk_rate;
  logic [7:0] prev_data;
  logic [6:0] lf_a;
  logic [6:0] win;
  int         nper, nzero, lat;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Output bit n obeys s[n] = s[n-7] ^ s[n-6], with the seed as the 7 preceding bits.
  function automatic void build_ref();
    logic       h [$];
    logic [6:0] sd;
    sd = SEED_V;
    for (int i = 6; i >= 0; i--) h.push_back(sd[i]);
    for (int n = 0; n < NBITS; n++) begin
      h.push_back(h[n] ^ h[n+1]);
      ref_s[n] = h[n+7];
    end
  endfunction

  function automatic logic [7:0] ref_byte(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = ref_s[8*k+i];
    return b;
  endfunction

  function automatic logic ref_frame(input int k);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) if (((8*k + i) % 127) == 0) hit = 1'b1;
    return FRAME_EN && hit;
  endfunction

  // scoreboard / monitor for the DIV=1 instance, run at the falling edge
  task automatic monitor1();
    if (rst1) begin
      exp_q.delete();
      exp_f_q.delete();
      got_bits.delete();
      for (int k = 0; k < NBYTES; k++) begin
        exp_q.push_back(ref_byte(k));
        exp_f_q.push_back(ref_frame(k));
      end
      first_seen = 1'b0;
      n_acc      = 0;
      prev_hold  = 1'b0;
    end else begin
      if (prev_hold) begin
        check_eq("hold_data", 32'(data1), 32'(prev_data));
        check_eq("hold_valid", 32'(vld1), 32'd1);
      end
      if (vld1 && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc1;
      end
      if (!vld1) check_eq("idle_frame", 32'(fs1), 32'd0);
      if (vld1 && rdy1) begin
        check_eq("sb_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          check_eq("byte", 32'(data1), 32'(exp_q.pop_front()));
          check_eq("frame", 32'(fs1), 32'(exp_f_q.pop_front()));
        end
        if (chk_rate && n_acc > 0) check_eq("rate", cyc1 - last_acc, 32'd8);
        last_acc = cyc1;
        n_acc++;
        for (int i = 7; i >= 0; i--) got_bits.push_back(data1[i]);
      end
      prev_hold = vld1 && !rdy1;
      prev_data = data1;
    end
  endtask

  // driver: inputs change 1ns after each rising edge
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor1();
      @(posedge clk);
      if (rst1) cyc1 = 0;
      else      cyc1++;
      #1;
    end
  endtask

  task automatic wait_first1(input int lim);
    int n;
    n = 0;
    while (!first_seen && n < lim) begin
      tick(1);
      n++;
    end
    check_eq("first_valid_seen", 32'(first_seen), 32'd1);
  endtask

  task automatic wait_acc1(input int cnt, input int lim);
    int n;
    n = 0;
    while (n_acc < cnt && n < lim) begin
      tick(1);
      n++;
    end
    check_eq("acc_count_reached", 32'(n_acc >= cnt), 32'd1);
  endtask

  task automatic run_div4(input int off_at, input int exp_lat);
    rst4 = 1'b1;
    en4  = 1'b1;
    rdy4 = 1'b1;
    tick(2);
    rst4 = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 120; c++) begin
      if (off_at > 0 && c == off_at) en4 = 1'b0;
      if (off_at > 0 && c == off_at + 10) en4 = 1'b1;
      tick(1);
      if (vld4) begin
        lat = c;
        break;
      end
    end
    check_eq("lat_div4", lat, exp_lat);
    check_eq("first_byte_div4", 32'(data4), 32'h06);
  endtask

  initial begin
    rst1 = 1'b1; en1 = 1'b1; rdy1 = 1'b1;
    rst4 = 1'b1; en4 = 1'b1; rdy4 = 1'b1;
    chk_rate = 1'b0; cyc1 = 0; first_cyc = 0; last_acc = 0; n_acc = 0;
    first_seen = 1'b0; prev_hold = 1'b0; prev_data = '0;
    build_ref();
    tick(3);
    check_eq("rst_data", 32'(data1), 32'h00);
    check_eq("rst_valid", 32'(vld1), 32'd0);
    check_eq("rst_frame", 32'(fs1), 32'd0);
    check_eq("rst4_data", 32'(data4), 32'h00);
    check_eq("rst4_valid", 32'(vld4), 32'd0);

    // free-running stream, ready tied high
    chk_rate = 1'b1;
    rst1 = 1'b0;
    wait_first1(50);
    check_eq("lat_div1", first_cyc, 32'd9);
    check_eq("first_byte", 32'(data1), 32'h06);
    wait_acc1(130, 1500);
    chk_rate = 1'b0;
    nper  = 0;
    nzero = 0;
    for (int i = 0; i + 127 < got_bits.size(); i++)
      if (got_bits[i] !== got_bits[i+127]) nper++;
    for (int i = 0; i + 7 <= got_bits.size(); i++) begin
      for (int j = 0; j < 7; j++) win[j] = got_bits[i+j];
      if (win == 7'd0) nzero++;
    end
    check_eq("bits_seen", 32'(got_bits.size() >= 1016), 32'd1);
    check_eq("period127", nper, 32'd0);
    check_eq("zero_window", nzero, 32'd0);

    // consumer stall for 40 cycles after the first byte
    rst1 = 1'b1; rdy1 = 1'b0;
    tick(1);
    rst1 = 1'b0;
    wait_first1(50);
    for (int i = 0; i < 40; i++) begin
      if (i == 20) lf_a = u_dut1.r_lfsr;
      tick(1);
    end
    check_eq("stall_data", 32'(data1), 32'h06);
    check_eq("stall_valid", 32'(vld1), 32'd1);
    check_eq("lfsr_frozen", 32'(u_dut1.r_lfsr), 32'(lf_a));
    rdy1 = 1'b1;
    wait_acc1(3, 200);

    // reset pulse mid-byte with a byte pending
    rst1 = 1'b1; rdy1 = 1'b0;
    tick(1);
    rst1 = 1'b0;
    wait_first1(50);
    tick(2);
    check_eq("mid_bit_cnt", 32'(u_dut1.r_bit_cnt), 32'd3);
    check_eq("mid_valid", 32'(vld1), 32'd1);
    rst1 = 1'b1;
    tick(1);
    check_eq("rst_mid_valid", 32'(vld1), 32'd0);
    rst1 = 1'b0; rdy1 = 1'b1;
    wait_first1(50);
    check_eq("lat_after_rst", first_cyc, 32'd9);
    check_eq("byte_after_rst", 32'(data1), 32'h06);

    // random ready / enable
    rst1 = 1'b1;
    tick(1);
    rst1 = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      rdy1 = ($urandom_range(0, 3) != 0);
      en1  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 199) == 0) begin
        rdy1 = 1'b0;
        tick(30);
      end
      tick(1);
    end
    en1 = 1'b1; rdy1 = 1'b1;
    tick(40);
    check_eq("rand_progress", 32'(n_acc > 100), 32'd1);

    // DIV=4 latency, then with a 10-cycle enable gap mid-byte
    rst1 = 1'b1;
    run_div4(0, 33);
    run_div4(11, 43);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
